program_counter: RTL and testbench

- 4-bit program counter for the 8-bit SAP-style CPU. It holds the address of the next instruction.
- Supports synchronous clear, increment, and jump (parallel load from the shared bus).
- Drives its value onto the shared tri-state bus under control of the output-enable input.
- Sits between the control sequencer (ce, j_n, co_n) and the system bus feeding the memory address register.

---
 rtl/pc_pkg.sv | 9 +
 rtl/program_counter_if.sv | 27 ++
 rtl/pc_counter.sv | 36 +++
 rtl/program_counter.sv | 30 +++
 tb/tb_program_counter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared program-counter width and address type, also used by the MAR and
// the control sequencer.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 4;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/program_counter_if.sv
// Control and status signals between the control sequencer and the program counter.
interface program_counter_if
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
) ();

    logic             ce;
    logic             j_n;
    logic             co_n;
    logic [WIDTH-1:0] pc;

    modport master (
        output ce,
        output j_n,
        output co_n,
        input  pc
    );

    modport slave (
        input  ce,
        input  j_n,
        input  co_n,
        output pc
    );

endinterface

// File: rtl/pc_counter.sv
// Registered clear / load / increment core of the program counter.
module pc_counter
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             ce_i,
    input  logic             load_ni,
    input  logic [WIDTH-1:0] load_data_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Clear beats load, load beats increment; increment wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (!load_ni) begin
            pc_d = load_data_i;
        end else if (ce_i) begin
            pc_d = pc_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        pc_q <= pc_d;
    end

    assign count_o = pc_q;

endmodule

// File: rtl/program_counter.sv
// SAP-style program counter: counter core plus the tri-state driver onto the shared bus.
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    program_counter_if.slave ctrl,
    inout  wire  [WIDTH-1:0] bus
);

    logic [WIDTH-1:0] count;

    pc_counter #(
        .WIDTH (WIDTH)
    ) u_pc_counter (
        .clk_i       (clk),
        .clr_i       (clr),
        .ce_i        (ctrl.ce),
        .load_ni     (ctrl.j_n),
        .load_data_i (bus),
        .count_o     (count)
    );

    // Released while loading so the external jump source never fights us.
    assign bus      = (ctrl.co_n && ctrl.j_n) ? count : {WIDTH{1'bz}};
    assign ctrl.pc  = count;

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized checks of program_counter against a behavioural model.
module tb_program_counter;

    logic       clk;
    logic       clr;
    logic       drv_en;
    logic [3:0] drv_val;
    wire  [3:0] bus;

    int vectors;
    int miscompares;
    int model;

    program_counter_if #(.WIDTH(4)) pc_if ();

    program_counter #(
        .WIDTH (4)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .ctrl (pc_if),
        .bus  (bus)
    );

    // External jump source; a released bus floats up to all ones.
    assign bus = drv_en ? drv_val : 4'bzzzz;
    for (genvar i = 0; i < 4; i++) begin : g_pull
        pullup (bus[i]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_bus();
        if (pc_if.co_n && pc_if.j_n) return 4'(model);
        if (drv_en) return drv_val;
        return 4'hF;
    endfunction

    // One rising edge; the model applies clear > jump > count > hold.
    task automatic tick();
        int nxt;
        if (clr) nxt = 0;
        else if (!pc_if.j_n) nxt = int'(drv_val);
        else if (pc_if.ce) nxt = (model + 1) % 16;
        else nxt = model;
        @(posedge clk);
        model = nxt;
        #1;
    endtask

    task automatic jump_to(input logic [3:0] val, input logic count_en);
        pc_if.j_n = 1'b0;
        pc_if.ce  = count_en;
        drv_en    = 1'b1;
        drv_val   = val;
        tick();
        pc_if.j_n = 1'b1;
        drv_en    = 1'b0;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model       = 0;
        drv_en      = 1'b0;
        drv_val     = 4'h0;
        clr         = 1'b1;
        pc_if.ce    = 1'b1;
        pc_if.j_n   = 1'b1;
        pc_if.co_n  = 1'b1;
        @(negedge clk);

        // Reset, then five increments
        tick();
        check("reset_pc", pc_if.pc, 4'h0);
        check("reset_bus", bus, 4'h0);
        clr = 1'b0;
        repeat (5) tick();
        check("count5_pc", pc_if.pc, 4'h5);
        check("count5_bus", bus, 4'h5);

        // Jump load; DUT must release the bus while j_n is low
        pc_if.ce  = 1'b0;
        pc_if.j_n = 1'b0;
        drv_en    = 1'b1;
        drv_val   = 4'b0101;
        #1;
        check("load_bus_ext", bus, 4'h5);
        tick();
        check("load_pc", pc_if.pc, 4'h5);
        pc_if.j_n = 1'b1;
        drv_en    = 1'b0;
        #1;
        check("after_load_bus", bus, 4'h5);

        // Output enable is combinational
        pc_if.co_n = 1'b0;
        #1;
        check("co_off_bus", bus, 4'hF);
        check("co_off_pc", pc_if.pc, 4'h5);
        pc_if.co_n = 1'b1;
        #1;
        check("co_on_bus", bus, 4'h5);

        // Jump to a value different from pc: bus must show only the external driver
        pc_if.j_n = 1'b0;
        drv_en    = 1'b1;
        drv_val   = 4'hE;
        #1;
        check("no_contention", bus, 4'hE);
        pc_if.j_n = 1'b1;
        drv_en    = 1'b0;
        jump_to(4'hE, 1'b0);
        pc_if.ce = 1'b1;
        tick();
        check("wrap_f", pc_if.pc, 4'hF);
        tick();
        check("wrap_0", pc_if.pc, 4'h0);

        // Load beats count, clear beats everything, count resumes from 0
        jump_to(4'h3, 1'b1);
        check("load_over_ce", pc_if.pc, 4'h3);
        clr       = 1'b1;
        pc_if.j_n = 1'b0;
        pc_if.ce  = 1'b1;
        drv_en    = 1'b1;
        drv_val   = 4'hA;
        tick();
        check("clr_over_all", pc_if.pc, 4'h0);
        clr       = 1'b0;
        pc_if.j_n = 1'b1;
        drv_en    = 1'b0;
        tick();
        check("resume", pc_if.pc, 4'h1);

        // Hold
        pc_if.ce = 1'b0;
        repeat (4) tick();
        check("hold", pc_if.pc, 4'h1);

        // Randomized control sequences
        for (int n = 0; n < 300; n++) begin
            clr        = ($urandom_range(0, 15) == 0);
            pc_if.j_n  = ($urandom_range(0, 3) != 0);
            pc_if.ce   = 1'($urandom);
            pc_if.co_n = 1'($urandom);
            drv_en     = !pc_if.j_n;
            drv_val    = 4'($urandom);
            #1;
            check("rnd_bus_pre", bus, exp_bus());
            tick();
            check("rnd_pc", pc_if.pc, 4'(model));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
